// File: rtl/spi_cmd_deserializer.sv
// Synchronous FIFO with first-word-fall-through output and a drop indication.
// Latency: a pushed entry is visible on pop_vld/pop_dat the cycle after the push.
// Backpressure: pop only when pop_vld & pop_rdy; a push while full with no pop is dropped.
module sync_fifo #(
  parameter int WIDTH      = 33,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push_vld,
  input  logic [WIDTH-1:0]      push_dat,
  output logic                  push_drop,
  output logic                  pop_vld,
  input  logic                  pop_rdy,
  output logic [WIDTH-1:0]      pop_dat,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count == DEPTH_CNT);
  assign pop_vld   = (count != '0);
  assign do_pop    = pop_vld & pop_rdy;
  // A pop frees the head slot at the same edge, so a push is accepted even when full.
  assign do_push   = push_vld & (~full | do_pop);
  assign push_drop = push_vld & full & ~do_pop;
  // Idle output is forced to zero so stale storage never shows on the bus.
  assign pop_dat   = pop_vld ? mem[rd_ptr] : '0;

  // Storage array, written at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally; count tracks occupancy including the full state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// SPI mode-0 slave that turns each chip-select frame into one AXIS packet of command words.
// Latency: word is staged 3 aclk after its last sck edge; it enters the FIFO on the next word or cs rise.
// Backpressure: words queue in the FIFO; serial_cts throttles the host; words arriving when full are dropped.
module spi_cmd_deserializer #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int CTS_THRESHOLD   = 4
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  serial_mosi,
  input  logic                  serial_sck,
  input  logic                  serial_cs,
  output logic                  serial_cts,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  overflow_err,
  output logic                  frame_err
);

  localparam int                         BIT_CNT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_CNT_W-1:0]       LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [FIFO_DEPTH_LOG2:0]   CTS_MIN   = (FIFO_DEPTH_LOG2 + 1)'(CTS_THRESHOLD);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RECEIVE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Synchroniser stages and previous-sample registers for edge detection.
  logic sck_s1, sck_s2, sck_prev;
  logic mosi_s1, mosi_s2;
  logic cs_s1, cs_s2, cs_prev;
  logic sck_rise;
  logic cs_rise;

  // Bit assembly.
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  byte_base;
  logic [6:0]            byte_sr;
  logic [7:0]            new_byte;
  logic [DATA_WIDTH-1:0] word_sr;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  word_done;

  // Staging register in front of the FIFO.
  logic [DATA_WIDTH-1:0] stage_dat;
  logic                  stage_vld;
  logic                  flush_pend;

  // FIFO interface.
  logic                     push_vld;
  logic                     push_last;
  logic                     push_drop;
  logic [DATA_WIDTH:0]      pop_dat;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic [FIFO_DEPTH_LOG2:0] free_cnt;

  // Two-flop synchronisers; cs resets low so WAIT_IDLE must see a genuine high before trusting a frame.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_prev <= 1'b0;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      cs_s1    <= 1'b0;
      cs_s2    <= 1'b0;
      cs_prev  <= 1'b0;
    end else begin
      sck_s1   <= serial_sck;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      mosi_s1  <= serial_mosi;
      mosi_s2  <= mosi_s1;
      cs_s1    <= serial_cs;
      cs_s2    <= cs_s1;
      cs_prev  <= cs_s2;
    end
  end

  assign sck_rise  = sck_s2 & ~sck_prev;
  assign cs_rise   = cs_s2 & ~cs_prev;
  assign word_done = (state == RECEIVE) && sck_rise && (bit_cnt == LAST_BIT);
  assign byte_base = bit_cnt & ~BIT_CNT_W'(7);

  // Insert the byte being completed into its little-endian lane of the word.
  always_comb begin
    new_byte                 = {byte_sr, mosi_s2};
    word_next                = word_sr;
    word_next[byte_base +: 8] = new_byte;
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a frame is only trusted once cs has been seen idle.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (cs_s2)   state_nxt = IDLE;
      IDLE:      if (!cs_s2)  state_nxt = RECEIVE;
      RECEIVE:   if (cs_rise) state_nxt = IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  // FIFO push selection: older staged word on completion, last word on cs rise or deferred flush.
  always_comb begin
    push_vld  = 1'b0;
    push_last = 1'b0;
    if (flush_pend) begin
      push_vld  = 1'b1;
      push_last = 1'b1;
    end else if (state == RECEIVE) begin
      if (word_done) begin
        push_vld = stage_vld;
      end else if (cs_rise) begin
        push_vld  = stage_vld;
        push_last = 1'b1;
      end
    end
  end

  // Bit/byte assembly, staging and sticky error flags.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      bit_cnt      <= '0;
      byte_sr      <= '0;
      word_sr      <= '0;
      stage_dat    <= '0;
      stage_vld    <= 1'b0;
      flush_pend   <= 1'b0;
      frame_err    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (flush_pend) begin
        stage_vld  <= 1'b0;
        flush_pend <= 1'b0;
      end
      if (state == IDLE && !cs_s2) begin
        bit_cnt <= '0;
      end
      if (state == RECEIVE) begin
        if (sck_rise) begin
          byte_sr <= new_byte[6:0];
          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          if (bit_cnt[2:0] == 3'd7) begin
            word_sr <= word_next;
          end
        end
        if (word_done) begin
          // The old stage (if any) leaves this cycle; a coincident cs rise defers the new last word by one cycle.
          stage_dat <= word_next;
          stage_vld <= 1'b1;
          if (cs_rise) begin
            flush_pend <= 1'b1;
          end
        end else if (cs_rise) begin
          stage_vld <= 1'b0;
          if (bit_cnt != '0) begin
            frame_err <= 1'b1;
          end
        end
      end
      if (push_drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH      (DATA_WIDTH + 1),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (aclk),
    .resetn    (resetn),
    .push_vld  (push_vld),
    .push_dat  ({push_last, stage_dat}),
    .push_drop (push_drop),
    .pop_vld   (m_axis_tvalid),
    .pop_rdy   (m_axis_tready),
    .pop_dat   (pop_dat),
    .count     (fifo_count)
  );

  assign m_axis_tdata = pop_dat[DATA_WIDTH-1:0];
  assign m_axis_tlast = pop_dat[DATA_WIDTH];
  assign free_cnt     = DEPTH_CNT - fifo_count;

  // Clear-to-send follows FIFO headroom one cycle late and stays low until a clean idle is seen.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      serial_cts <= 1'b0;
    end else begin
      serial_cts <= (state != WAIT_IDLE) && (free_cnt >= CTS_MIN);
    end
  end

endmodule

// File: tb/tb_spi_cmd_deserializer.sv
module tb_spi_cmd_deserializer;

  logic        aclk = 1'b0;
  logic        resetn;
  logic        serial_mosi;
  logic        serial_sck;
  logic        serial_cs;
  logic        serial_cts;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        overflow_err;
  logic        frame_err;

  logic        ready_drv;
  logic        toggle_en;
  logic        tog_phase;

  int checks;
  int errors;

  logic [31:0] q_dat [$];
  logic        q_last [$];
  int          stab_viol;
  logic        hold_pend;
  logic [31:0] hold_dat;
  logic        hold_last;

  localparam logic [31:0] B2B_VALS [4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDEADBEEF};

  assign m_axis_tready = toggle_en ? tog_phase : ready_drv;

  always #5 aclk = ~aclk;

  spi_cmd_deserializer #(
    .DATA_WIDTH      (32),
    .FIFO_DEPTH_LOG2 (4),
    .CTS_THRESHOLD   (4)
  ) dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .serial_mosi   (serial_mosi),
    .serial_sck    (serial_sck),
    .serial_cs     (serial_cs),
    .serial_cts    (serial_cts),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .overflow_err  (overflow_err),
    .frame_err     (frame_err)
  );

  // tready toggles every cycle, changing just after the active edge
  initial begin
    tog_phase = 1'b0;
    forever begin
      @(posedge aclk);
      #1 tog_phase = ~tog_phase;
    end
  end

  // Beat capture and stall-stability monitor, sampled on the falling edge
  initial begin
    stab_viol = 0;
    hold_pend = 1'b0;
    hold_dat  = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge aclk);
      if (!resetn) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend && (!m_axis_tvalid || m_axis_tdata !== hold_dat || m_axis_tlast !== hold_last))
          stab_viol++;
        if (m_axis_tvalid && m_axis_tready) begin
          q_dat.push_back(m_axis_tdata);
          q_last.push_back(m_axis_tlast);
        end
        hold_pend = m_axis_tvalid && !m_axis_tready;
        hold_dat  = m_axis_tdata;
        hold_last = m_axis_tlast;
      end
    end
  end

  function automatic logic [31:0] word_of(input int k);
    return {8'(k + 192), 8'(k + 128), 8'(k + 64), 8'(k)};
  endfunction

  // One byte MSB-first, sck half period of 4 aclk; optional one-cycle tready pulse on the edge that pushes.
  task automatic spi_byte(input logic [7:0] b, input logic pulse);
    for (int i = 7; i >= 0; i--) begin
      serial_mosi = b[i];
      repeat (4) @(posedge aclk);
      #1 serial_sck = 1'b1;
      if (pulse && i == 0) begin
        @(posedge aclk);
        @(posedge aclk);
        #1 ready_drv = 1'b1;
        @(posedge aclk);
        #1 ready_drv = 1'b0;
        @(posedge aclk);
      end else begin
        repeat (4) @(posedge aclk);
      end
      #1 serial_sck = 1'b0;
    end
  endtask

  task automatic spi_word(input logic [31:0] w, input logic pulse);
    spi_byte(w[7:0], 1'b0);
    spi_byte(w[15:8], 1'b0);
    spi_byte(w[23:16], 1'b0);
    spi_byte(w[31:24], pulse);
    repeat (4) @(posedge aclk);
  endtask

  task automatic frame_start();
    @(posedge aclk);
    #1 serial_cs = 1'b0;
    repeat (8) @(posedge aclk);
  endtask

  task automatic frame_end();
    repeat (8) @(posedge aclk);
    #1 serial_cs = 1'b1;
    repeat (16) @(posedge aclk);
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1 resetn = 1'b0;
    repeat (4) @(posedge aclk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge aclk);
    q_dat.delete();
    q_last.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0; serial_cs = 1'b1; serial_sck = 1'b0; serial_mosi = 1'b0;
    ready_drv = 1'b0; toggle_en = 1'b0;
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_axis_tdata); end
    checks++; if (serial_cts !== 1'b0) begin errors++; $display("FAIL rst_cts got %b want 0", serial_cts); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b want 0", frame_err); end
    @(posedge aclk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    checks++; if (serial_cts !== 1'b1) begin errors++; $display("FAIL idle_cts got %b want 1", serial_cts); end
  endtask

  task automatic test_basic();
    q_dat.delete(); q_last.delete();
    ready_drv = 1'b1;
    frame_start();
    for (int b = 1; b <= 8; b++) spi_byte(8'(b), 1'b0);
    frame_end();
    @(negedge aclk);
    checks++; if (q_dat.size() != 2) begin errors++; $display("FAIL basic_beats got %0d want 2", q_dat.size()); end
    checks++; if (q_dat.size() < 1 || q_dat[0] !== 32'h04030201 || q_last[0] !== 1'b0) begin errors++; $display("FAIL basic_beat0 got %h/%b want 04030201/0", q_dat.size() > 0 ? q_dat[0] : 32'h0, q_dat.size() > 0 ? q_last[0] : 1'b0); end
    checks++; if (q_dat.size() < 2 || q_dat[1] !== 32'h08070605 || q_last[1] !== 1'b1) begin errors++; $display("FAIL basic_beat1 got %h/%b want 08070605/1", q_dat.size() > 1 ? q_dat[1] : 32'h0, q_dat.size() > 1 ? q_last[1] : 1'b0); end
    checks++; if (overflow_err !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL basic_errs got ovf=%b ferr=%b want 0/0", overflow_err, frame_err); end
  endtask

  task automatic test_overflow();
    do_reset();
    ready_drv = 1'b0;
    frame_start();
    for (int k = 0; k < 20; k++) begin
      spi_word(word_of(k), 1'b0);
      @(negedge aclk);
      if (k == 12) begin
        checks++; if (serial_cts !== 1'b1) begin errors++; $display("FAIL cts_12_used got %b want 1", serial_cts); end
      end
      if (k == 13) begin
        checks++; if (serial_cts !== 1'b0) begin errors++; $display("FAIL cts_13_used got %b want 0", serial_cts); end
      end
      if (k == 16) begin
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_16_stored got %b want 0", overflow_err); end
      end
      if (k == 17) begin
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_17th_word got %b want 1", overflow_err); end
      end
    end
    frame_end();
    @(posedge aclk);
    #1 ready_drv = 1'b1;
    repeat (40) @(posedge aclk);
    @(negedge aclk);
    checks++; if (q_dat.size() != 16) begin errors++; $display("FAIL drain_count got %0d want 16", q_dat.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= q_dat.size() || q_dat[i] !== word_of(i) || q_last[i] !== 1'b0) begin
        errors++;
        $display("FAIL drain_word%0d got %h want %h/0 (beats %0d)", i, i < q_dat.size() ? q_dat[i] : 32'h0, word_of(i), q_dat.size());
      end
    end
    checks++; if (serial_cts !== 1'b1 || overflow_err !== 1'b1) begin errors++; $display("FAIL drain_flags got cts=%b ovf=%b want 1/1", serial_cts, overflow_err); end
  endtask

  task automatic test_frame_err();
    do_reset();
    ready_drv = 1'b1;
    frame_start();
    for (int b = 1; b <= 6; b++) spi_byte(8'(b), 1'b0);
    frame_end();
    @(negedge aclk);
    checks++; if (q_dat.size() != 1 || q_dat[0] !== 32'h04030201 || q_last[0] !== 1'b1) begin errors++; $display("FAIL partial_beat got %0d beats %h want 1 beat 04030201/1", q_dat.size(), q_dat.size() > 0 ? q_dat[0] : 32'h0); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL partial_ferr got %b want 1", frame_err); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL partial_ovf got %b want 0", overflow_err); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    ready_drv = 1'b1;
    frame_start();
    spi_byte(8'h11, 1'b0);
    spi_byte(8'h22, 1'b0);
    @(posedge aclk);
    #1 resetn = 1'b0;
    repeat (4) @(posedge aclk);
    #1 resetn = 1'b1;
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    checks++; if (serial_cts !== 1'b0) begin errors++; $display("FAIL wait_idle_cts got %b want 0", serial_cts); end
    spi_byte(8'h33, 1'b0);
    spi_byte(8'h44, 1'b0);
    frame_end();
    @(negedge aclk);
    checks++; if (q_dat.size() != 0) begin errors++; $display("FAIL aborted_frame_beats got %0d want 0", q_dat.size()); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL aborted_frame_ferr got %b want 0", frame_err); end
    frame_start();
    spi_byte(8'hDD, 1'b0);
    spi_byte(8'hCC, 1'b0);
    spi_byte(8'hBB, 1'b0);
    spi_byte(8'hAA, 1'b0);
    frame_end();
    @(negedge aclk);
    checks++; if (q_dat.size() != 1 || q_dat[0] !== 32'hAABBCCDD || q_last[0] !== 1'b1) begin errors++; $display("FAIL post_reset_beat got %0d beats %h want 1 beat AABBCCDD/1", q_dat.size(), q_dat.size() > 0 ? q_dat[0] : 32'h0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    stab_viol = 0;
    toggle_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      frame_start();
      spi_word(B2B_VALS[f], 1'b0);
      frame_end();
    end
    repeat (20) @(posedge aclk);
    @(negedge aclk);
    toggle_en = 1'b0;
    checks++; if (q_dat.size() != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", q_dat.size()); end
    for (int f = 0; f < 4; f++) begin
      checks++;
      if (f >= q_dat.size() || q_dat[f] !== B2B_VALS[f] || q_last[f] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_beat%0d got %h want %h/1", f, f < q_dat.size() ? q_dat[f] : 32'h0, B2B_VALS[f]);
      end
    end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL b2b_stable got %0d changes want 0", stab_viol); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    ready_drv = 1'b0;
    frame_start();
    for (int k = 0; k < 17; k++) spi_word(word_of(k), 1'b0);
    @(negedge aclk);
    checks++; if (serial_cts !== 1'b0 || overflow_err !== 1'b0) begin errors++; $display("FAIL full_before got cts=%b ovf=%b want 0/0", serial_cts, overflow_err); end
    spi_word(word_of(17), 1'b1);
    @(negedge aclk);
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got %b want 0", overflow_err); end
    checks++; if (q_dat.size() != 1 || q_dat[0] !== word_of(0)) begin errors++; $display("FAIL full_pushpop_pop got %0d beats %h want 1 beat %h", q_dat.size(), q_dat.size() > 0 ? q_dat[0] : 32'h0, word_of(0)); end
    checks++; if (serial_cts !== 1'b0) begin errors++; $display("FAIL full_pushpop_cts got %b want 0", serial_cts); end
    @(posedge aclk);
    #1 ready_drv = 1'b1;
    repeat (40) @(posedge aclk);
    frame_end();
    @(negedge aclk);
    checks++; if (q_dat.size() != 18) begin errors++; $display("FAIL full_total got %0d want 18", q_dat.size()); end
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (i >= q_dat.size() || q_dat[i] !== word_of(i) || q_last[i] !== (i == 17)) begin
        errors++;
        $display("FAIL full_order%0d got %h/%b want %h/%b", i, i < q_dat.size() ? q_dat[i] : 32'h0, i < q_dat.size() ? q_last[i] : 1'b0, word_of(i), (i == 17));
      end
    end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL full_final_ovf got %b want 0", overflow_err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_frame_err();
    test_reset_midframe();
    test_back_to_back();
    test_full_push_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
